alu_result_stage: RTL and testbench

ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

---
 rtl/alu_result_stage_if.sv | 41 ++++
 rtl/alu_result_stage.sv | 94 +++++++++
 tb/tb_alu_result_stage.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_result_stage_if.sv
// Handshake bundle between an ALU and its result stage: push side, pop side,
// sticky flag status and drop statistics.
interface alu_result_stage_if #(
   parameter int WIDTH  = 32,
   parameter int OP_LEN = 5,
   parameter int DEPTH  = 4
);
   localparam int LW = $clog2(DEPTH) + 1;

   logic              in_valid;
   logic              in_ready;
   logic [OP_LEN-1:0] in_opcode;
   logic [WIDTH-1:0]  in_result;
   logic              in_cout;
   logic              in_neg;
   logic              in_ovf;
   logic              in_zero;
   logic              out_valid;
   logic              out_ready;
   logic [WIDTH-1:0]  out_result;
   logic [OP_LEN-1:0] out_opcode;
   logic [3:0]        out_flags;
   logic [3:0]        sticky_flags;
   logic              sticky_clr;
   logic [15:0]       drop_cnt;
   logic [LW-1:0]     level;

   modport slave (
      input  in_valid, in_opcode, in_result, in_cout, in_neg, in_ovf, in_zero,
      input  out_ready, sticky_clr,
      output in_ready, out_valid, out_result, out_opcode, out_flags,
      output sticky_flags, drop_cnt, level
   );

   modport master (
      output in_valid, in_opcode, in_result, in_cout, in_neg, in_ovf, in_zero,
      output out_ready, sticky_clr,
      input  in_ready, out_valid, out_result, out_opcode, out_flags,
      input  sticky_flags, drop_cnt, level
   );
endinterface

// File: rtl/alu_result_stage.sv
// ALU result FIFO: legal opcodes (1..3) are queued with flags, others are counted and dropped.
// One-cycle latency to head; in_ready drops when full (registered), out_valid holds until out_ready.
module alu_result_stage #(
   parameter int WIDTH  = 32,
   parameter int OP_LEN = 5,
   parameter int DEPTH  = 4
) (
   input logic               clk,
   input logic               rst_n,
   alu_result_stage_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;
   localparam logic [LW-1:0] FULL = LW'(DEPTH);

   typedef struct packed {
      logic [WIDTH-1:0]  result;
      logic [OP_LEN-1:0] opcode;
      logic [3:0]        flags;
   } entry_t;

   entry_t        mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic [3:0]    sticky_q, sticky_d;
   logic [15:0]   drop_cnt_q, drop_cnt_d;
   logic          legal, xfer, push, drop, pop;
   entry_t        in_entry, head;

   always_comb begin
      in_entry.result = bus.in_result;
      in_entry.opcode = bus.in_opcode;
      in_entry.flags  = {bus.in_cout, bus.in_neg, bus.in_ovf, bus.in_zero};

      legal = (bus.in_opcode == OP_LEN'(1)) || (bus.in_opcode == OP_LEN'(2)) ||
              (bus.in_opcode == OP_LEN'(3));
      // Acceptance looks only at registered occupancy, so a same-cycle pop never opens a full FIFO.
      xfer  = bus.in_valid && (level_q != FULL);
      push  = xfer && legal;
      drop  = xfer && !legal;
      pop   = (level_q != '0) && bus.out_ready;

      wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
      level_d  = level_q + LW'(push) - LW'(pop);

      sticky_d = sticky_q;
      if (push) begin
         sticky_d = bus.sticky_clr ? in_entry.flags : (sticky_q | in_entry.flags);
      end else if (bus.sticky_clr) begin
         sticky_d = '0;
      end

      drop_cnt_d = drop_cnt_q;
      if (drop && (drop_cnt_q != 16'hFFFF)) begin
         drop_cnt_d = drop_cnt_q + 16'd1;
      end

      head = (level_q != '0) ? mem_q[rd_ptr_q] : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         sticky_q   <= '0;
         drop_cnt_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         sticky_q   <= sticky_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   // Storage needs no reset: entries are only visible through level_q.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= in_entry;
      end
   end

   assign bus.in_ready     = (level_q != FULL);
   assign bus.out_valid    = (level_q != '0);
   assign bus.out_result   = head.result;
   assign bus.out_opcode   = head.opcode;
   assign bus.out_flags    = head.flags;
   assign bus.sticky_flags = sticky_q;
   assign bus.drop_cnt     = drop_cnt_q;
   assign bus.level        = level_q;
endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: a queue-based reference model fed at each clock edge,
// with a negedge monitor comparing the DUT head and status against it.
module tb_alu_result_stage;
   localparam int DEPTH = 4;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  op;
      logic [3:0]  flg;
   } ent_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   alu_result_stage_if bus ();

   alu_result_stage dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial forever #5 clk = ~clk;

   ent_t        exp_q[$];
   int          mdl_level  = 0;
   logic [3:0]  mdl_sticky = '0;
   int          mdl_drop   = 0;
   int          n_vec      = 0;
   int          n_err      = 0;
   bit          m_xfer, m_pop;
   ent_t        m_ent;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit is_legal(input logic [4:0] op);
      return (op == 5'd1) || (op == 5'd2) || (op == 5'd3);
   endfunction

   task automatic model_clear();
      exp_q.delete();
      mdl_level  = 0;
      mdl_sticky = '0;
      mdl_drop   = 0;
   endtask

   // Reference model: FIFO as a queue, occupancy as an integer, sticky as a running OR.
   always @(posedge clk) begin
      if (rst_n) begin
         m_xfer = bus.in_valid && (mdl_level != DEPTH);
         m_pop  = (mdl_level != 0) && bus.out_ready;
         if (m_xfer && is_legal(bus.in_opcode)) begin
            m_ent.res = bus.in_result;
            m_ent.op  = bus.in_opcode;
            m_ent.flg = {bus.in_cout, bus.in_neg, bus.in_ovf, bus.in_zero};
            exp_q.push_back(m_ent);
            mdl_sticky = bus.sticky_clr ? m_ent.flg : (mdl_sticky | m_ent.flg);
            mdl_level++;
         end else begin
            if (m_xfer && mdl_drop < 65535) mdl_drop++;
            if (bus.sticky_clr) mdl_sticky = '0;
         end
         if (m_pop) mdl_level--;
      end
   end

   // Monitor: compares state mid-cycle; pops the scoreboard when the head will be taken.
   always @(negedge clk) begin
      if (rst_n) begin
         check("level", 64'(bus.level), 64'(mdl_level));
         check("in_ready", 64'(bus.in_ready), 64'(mdl_level != DEPTH));
         check("out_valid", 64'(bus.out_valid), 64'(mdl_level != 0));
         check("sticky_flags", 64'(bus.sticky_flags), 64'(mdl_sticky));
         check("drop_cnt", 64'(bus.drop_cnt), 64'(mdl_drop));
         if (bus.out_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_head", 64'(bus.out_result), 64'hDEAD_0000_0000_0000);
            end else begin
               check("head_result", 64'(bus.out_result), 64'(exp_q[0].res));
               check("head_opcode", 64'(bus.out_opcode), 64'(exp_q[0].op));
               check("head_flags", 64'(bus.out_flags), 64'(exp_q[0].flg));
               if (bus.out_ready) void'(exp_q.pop_front());
            end
         end else begin
            check("idle_outputs", 64'({bus.out_result, bus.out_opcode, bus.out_flags}), 64'd0);
         end
      end
   end

   task automatic drive(input logic v, input logic [4:0] op, input logic [31:0] r,
                        input logic [3:0] f, input logic ordy, input logic clr);
      bus.in_valid  = v;
      bus.in_opcode = op;
      bus.in_result = r;
      {bus.in_cout, bus.in_neg, bus.in_ovf, bus.in_zero} = f;
      bus.out_ready  = ordy;
      bus.sticky_clr = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_level"}, 64'(bus.level), 64'd0);
      check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
      check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
      check({tag, "_outputs"}, 64'({bus.out_result, bus.out_opcode, bus.out_flags}), 64'd0);
      check({tag, "_sticky"}, 64'(bus.sticky_flags), 64'd0);
      check({tag, "_drop"}, 64'(bus.drop_cnt), 64'd0);
   endtask

   initial begin
      logic [4:0] op;
      bus.in_valid = 1'b0; bus.in_opcode = '0; bus.in_result = '0;
      bus.in_cout = 1'b0; bus.in_neg = 1'b0; bus.in_ovf = 1'b0; bus.in_zero = 1'b0;
      bus.out_ready = 1'b0; bus.sticky_clr = 1'b0;
      #1;
      check_reset_values("por");
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Single pass through the stage
      drive(1'b1, 5'd1, 32'h0000_0005, 4'b0000, 1'b1, 1'b0);
      check("single_valid", 64'(bus.out_valid), 64'd1);
      check("single_result", 64'(bus.out_result), 64'd5);
      check("single_opcode", 64'(bus.out_opcode), 64'd1);
      drive(1'b0, 5'd0, 32'h0, 4'b0000, 1'b1, 1'b0);
      check("single_popped", 64'(bus.out_valid), 64'd0);

      // Fill against back-pressure, then drain and wrap the pointers
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 5'(1 + i % 3), 32'h100 + 32'(i), 4'(i), 1'b0, 1'b0);
         if (i == 3) begin
            check("full_in_ready", 64'(bus.in_ready), 64'd0);
            check("full_level", 64'(bus.level), 64'd4);
         end
      end
      check("full_level_after5", 64'(bus.level), 64'd4);
      for (int i = 0; i < 5; i++) drive(1'b0, 5'd0, 32'h0, 4'b0000, 1'b1, 1'b0);
      check("drained", 64'(bus.out_valid), 64'd0);
      for (int i = 0; i < 4; i++) drive(1'b1, 5'd2, 32'h200 + 32'(i), 4'(15 - i), 1'b0, 1'b0);
      check("wrap_level", 64'(bus.level), 64'd4);
      for (int i = 0; i < 5; i++) drive(1'b0, 5'd0, 32'h0, 4'b0000, 1'b1, 1'b0);

      // Illegal opcodes and drop counter saturation
      drive(1'b1, 5'd0, 32'h11, 4'b1111, 1'b1, 1'b0);
      drive(1'b1, 5'd4, 32'h22, 4'b1111, 1'b1, 1'b0);
      drive(1'b1, 5'd31, 32'h33, 4'b1111, 1'b1, 1'b0);
      check("illegal_level", 64'(bus.level), 64'd0);
      check("illegal_drop", 64'(bus.drop_cnt), 64'd3);
      for (int i = 0; i < 65540; i++) begin
         op = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(4, 31));
         drive(1'b1, op, $urandom, 4'($urandom), 1'b1, 1'b0);
      end
      check("drop_saturated", 64'(bus.drop_cnt), 64'hFFFF);

      // Sticky flags
      drive(1'b0, 5'd0, 32'h0, 4'b0000, 1'b1, 1'b1);
      drive(1'b1, 5'd1, 32'h51, 4'b1000, 1'b1, 1'b0);
      drive(1'b1, 5'd2, 32'h52, 4'b0001, 1'b1, 1'b0);
      check("sticky_or", 64'(bus.sticky_flags), 64'b1001);
      drive(1'b1, 5'd3, 32'h53, 4'b0100, 1'b1, 1'b1);
      check("sticky_clr_push", 64'(bus.sticky_flags), 64'b0100);
      drive(1'b0, 5'd0, 32'h0, 4'b0000, 1'b1, 1'b1);
      check("sticky_clr", 64'(bus.sticky_flags), 64'd0);

      // Steady push+pop at level 2
      drive(1'b1, 5'd1, 32'h300, 4'b0010, 1'b0, 1'b0);
      drive(1'b1, 5'd2, 32'h301, 4'b0100, 1'b0, 1'b0);
      check("pp_prefill", 64'(bus.level), 64'd2);
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 5'(1 + i % 3), 32'h400 + 32'(i), 4'($urandom), 1'b1, 1'b0);
         check("pp_level", 64'(bus.level), 64'd2);
      end
      for (int i = 0; i < 3; i++) drive(1'b0, 5'd0, 32'h0, 4'b0000, 1'b1, 1'b0);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         drive(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 5)), $urandom, 4'($urandom),
               1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
      end
      for (int i = 0; i < 6; i++) drive(1'b0, 5'd0, 32'h0, 4'b0000, 1'b1, 1'b0);

      // Asynchronous reset with three entries stored and a beat pending
      for (int i = 0; i < 3; i++) drive(1'b1, 5'd1, 32'h600 + 32'(i), 4'b0001, 1'b0, 1'b0);
      check("pre_reset_level", 64'(bus.level), 64'd3);
      #2;
      rst_n = 1'b0;
      model_clear();
      #1;
      check_reset_values("async");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive(1'b1, 5'd2, 32'h0000_ABCD, 4'b0010, 1'b0, 1'b0);
      check("post_reset_valid", 64'(bus.out_valid), 64'd1);
      check("post_reset_head", 64'(bus.out_result), 64'hABCD);
      check("post_reset_level", 64'(bus.level), 64'd1);
      drive(1'b0, 5'd0, 32'h0, 4'b0000, 1'b1, 1'b0);
      drive(1'b0, 5'd0, 32'h0, 4'b0000, 1'b1, 1'b0);
      check("final_scoreboard_empty", 64'(exp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
